// File: rtl/fact_pkg.sv
// Shared types and constants for the factorial controller.
package fact_pkg;

   localparam int unsigned FACT_SIZE  = 8;
   localparam int unsigned FACT_MAX_N = 5;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      INIT = 3'd1,
      TEST = 3'd2,
      MUL  = 3'd3,
      DONE = 3'd4,
      ERR  = 3'd5
   } state_t;

endpackage

// File: rtl/fact_ctrl.sv
// Sequencing FSM for the factorial datapath: host go/done/ack handshake,
// operand range screening, abort, and a loop watchdog guarding against a stuck comparator.
module fact_ctrl
   import fact_pkg::*;
#(
   parameter int unsigned SIZE  = FACT_SIZE,
   parameter int unsigned MAX_N = FACT_MAX_N
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            go,
   input  logic            ack,
   input  logic            abort,
   input  logic [SIZE-1:0] n,
   input  logic            proceed,
   output logic            cnt_load,
   output logic            cnt_en,
   output logic            reg_sel,
   output logic            reg_load,
   output logic            busy,
   output logic            done,
   output logic            err
);

   localparam int unsigned WD_W = $clog2(MAX_N + 1);

   state_t          state_q, state_d;
   logic [WD_W-1:0] wd_q, wd_d;
   logic            n_ok;
   logic            wd_hit;

   assign n_ok   = (n <= SIZE'(MAX_N));
   assign wd_hit = (wd_q == WD_W'(MAX_N));

   // State and watchdog registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         wd_q    <= wd_d;
      end
   end

   // Next state and control decode; abort suppresses all strobes in its cycle
   always_comb begin
      state_d  = state_q;
      wd_d     = wd_q;
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
      reg_sel  = 1'b0;
      reg_load = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      err      = 1'b0;
      case (state_q)
         IDLE: begin
            if (go) state_d = n_ok ? INIT : ERR;
         end
         INIT: begin
            busy = 1'b1;
            if (abort) begin
               state_d = IDLE;
            end else begin
               cnt_load = 1'b1;
               reg_load = 1'b1;
               reg_sel  = 1'b1;
               wd_d     = '0;
               state_d  = TEST;
            end
         end
         TEST: begin
            busy = 1'b1;
            if (abort) begin
               state_d = IDLE;
            end else if (proceed) begin
               cnt_en  = 1'b1;
               state_d = MUL;
            end else begin
               state_d = DONE;
            end
         end
         MUL: begin
            busy = 1'b1;
            if (abort) begin
               state_d = IDLE;
            end else begin
               reg_load = 1'b1;
               if (!wd_hit) wd_d = wd_q + WD_W'(1);
               state_d = wd_hit ? ERR : TEST;
            end
         end
         DONE: begin
            done = 1'b1;
            if (ack) state_d = IDLE;
         end
         ERR: begin
            err = 1'b1;
            if (ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_fact_ctrl.sv
// Bench for fact_ctrl with a behavioural datapath; results checked against n! and the
// 2*max(n,1)+1 latency rule.
module tb_fact_ctrl;
   import fact_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n, go, ack, abort, proceed;
   logic [7:0] n;
   logic       cnt_load, cnt_en, reg_sel, reg_load, busy, done, err;

   logic [7:0] cnt_q = 8'd0;
   logic [7:0] reg_q = 8'd0;
   logic       force_proceed = 1'b0;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fact_ctrl dut (
      .clk(clk), .rst_n(rst_n), .go(go), .ack(ack), .abort(abort), .n(n),
      .proceed(proceed), .cnt_load(cnt_load), .cnt_en(cnt_en), .reg_sel(reg_sel),
      .reg_load(reg_load), .busy(busy), .done(done), .err(err)
   );

   // Datapath: counter, multiplier, mux, register, comparator
   always_ff @(posedge clk) begin
      if (cnt_load)    cnt_q <= 8'd1;
      else if (cnt_en) cnt_q <= cnt_q + 8'd1;
      if (reg_load)    reg_q <= reg_sel ? 8'd1 : 8'(cnt_q * reg_q);
   end
   assign proceed = force_proceed | (n > cnt_q);

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int fact_ref(input int k);
      int p = 1;
      for (int i = 2; i <= k; i++) p = p * i;
      return p % 256;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One go/done(err)/ack transaction with random noise on ignored inputs
   task automatic run_op(input int nv, input int ack_delay);
      int cyc, busy_cnt, done_cyc, err_cyc, strobes, exp_done;
      n = 8'(nv);
      go = 1'b1;
      tick();
      go = 1'b0;
      cyc = 1; busy_cnt = 0; done_cyc = 0; err_cyc = 0; strobes = 0;
      while (cyc <= 40) begin
         if (done) begin done_cyc = cyc; break; end
         if (err)  begin err_cyc = cyc;  break; end
         if (busy) busy_cnt++;
         if (cnt_load || reg_load) strobes++;
         go  = 1'($urandom % 2);
         ack = 1'($urandom % 2);
         tick();
         cyc++;
      end
      go = 1'b0; ack = 1'b0;
      if (nv > FACT_MAX_N) begin
         check($sformatf("err_cycle n=%0d", nv), err_cyc, 1);
         check($sformatf("err_no_strobe n=%0d", nv), strobes, 0);
      end else begin
         exp_done = 2 * ((nv > 1) ? nv : 1) + 1;
         check($sformatf("done_cycle n=%0d", nv), done_cyc, exp_done);
         check($sformatf("result n=%0d", nv), int'(reg_q), fact_ref(nv));
         check($sformatf("busy_cycles n=%0d", nv), busy_cnt, exp_done - 1);
      end
      for (int i = 0; i < ack_delay; i++) tick();
      check($sformatf("hold n=%0d", nv), int'({done, err}), (nv > FACT_MAX_N) ? 1 : 2);
      ack = 1'b1;
      go  = 1'($urandom % 2);
      tick();
      ack = 1'b0; go = 1'b0;
      check($sformatf("idle_after_ack n=%0d", nv), int'({busy, done, err}), 0);
      tick();
      check($sformatf("no_restart n=%0d", nv), int'({busy, done, err}), 0);
   endtask

   initial begin
      int seen_err, seen_done;
      rst_n = 1'b0; go = 1'b0; ack = 1'b0; abort = 1'b0; n = 8'd0;
      tick(); tick();
      check("reset_outputs",
            int'({cnt_load, cnt_en, reg_sel, reg_load, busy, done, err}), 0);
      rst_n = 1'b1;
      tick();
      check("idle_outputs",
            int'({cnt_load, cnt_en, reg_sel, reg_load, busy, done, err}), 0);

      // Directed operands, including boundaries
      run_op(3, 0);
      run_op(0, 1);
      run_op(1, 0);
      run_op(5, 2);
      run_op(6, 0);
      run_op(255, 1);

      // Randomized operands
      for (int t = 0; t < 20; t++) run_op(int'($urandom_range(0, 9)), int'($urandom_range(0, 3)));

      // Abort in MUL (n=4: INIT 1, TEST 2, MUL 3)
      n = 8'd4; go = 1'b1; tick(); go = 1'b0;
      tick(); tick();
      check("abort_pre_mul_busy", int'(busy), 1);
      abort = 1'b1;
      #1;
      check("abort_no_strobe", int'({cnt_load, cnt_en, reg_load}), 0);
      tick();
      abort = 1'b0;
      check("abort_to_idle", int'({busy, done, err}), 0);
      seen_done = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) seen_done = 1;
         tick();
      end
      check("abort_no_done", seen_done, 0);
      run_op(2, 0);

      // Abort is ignored in DONE
      n = 8'd1; go = 1'b1; tick(); go = 1'b0;
      tick(); tick();
      abort = 1'b1; tick(); abort = 1'b0;
      check("abort_ignored_done", int'(done), 1);
      ack = 1'b1; tick(); ack = 1'b0;

      // Synchronous reset mid-run
      n = 8'd5; go = 1'b1; tick(); go = 1'b0;
      tick(); tick();
      rst_n = 1'b0;
      tick();
      check("midrun_reset",
            int'({cnt_load, cnt_en, reg_sel, reg_load, busy, done, err}), 0);
      rst_n = 1'b1;
      tick();
      run_op(5, 0);

      // Stuck comparator trips the watchdog
      force_proceed = 1'b1;
      n = 8'd2; go = 1'b1; tick(); go = 1'b0;
      seen_err = 0; seen_done = 0;
      for (int i = 0; i < 40 && !seen_err; i++) begin
         if (done) seen_done = 1;
         if (err)  seen_err = 1;
         else      tick();
      end
      check("watchdog_err", seen_err, 1);
      check("watchdog_no_done", seen_done, 0);
      force_proceed = 1'b0;
      ack = 1'b1; tick(); ack = 1'b0;
      check("watchdog_ack_idle", int'({busy, done, err}), 0);

      // go and ack together in DONE: ack wins, no restart
      n = 8'd1; go = 1'b1; tick(); go = 1'b0;
      tick(); tick();
      check("goack_in_done", int'(done), 1);
      go = 1'b1; ack = 1'b1;
      tick();
      go = 1'b0; ack = 1'b0;
      check("goack_idle", int'({busy, done, err}), 0);
      tick();
      check("goack_no_restart", int'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
